// File: rtl/load_store_unit_if.sv
// load_store_unit_if: memory-side request/acknowledge bus of the load/store unit.
// The LSU is the master (drives the request), the memory is the slave.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer (IDLE -> BUSY -> DONE).
// Checks alignment, builds byte enables and replicated store data, holds the
// request on the memory bus until acknowledged, and returns extended load data.
// Optional build macro: LSU_TIMEOUT_EN adds a BUSY-cycle watchdog that aborts
// the access after TIMEOUT_CYCLES, returns 32'hDEADBEEF for loads and pulses BusErr.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [31:0]           ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  MisalignErr,
    output logic                  BusErr,
    load_store_unit_if.master     mem
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } lsu_req_t;

    state_t      state, state_nxt;
    lsu_req_t    req_q, req_d;
    logic        is_byte, is_half, aligned, request;
    logic        accept, timeout, timeout_hit;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;

    // Decode access size, alignment, byte lanes and replicated store data
    always_comb begin
        is_byte    = (funct3[1:0] == 2'b00);
        is_half    = (funct3[1:0] == 2'b01);
        request    = MemRead | MemWrite;
        req_d.addr = ALUResult;
        req_d.we   = MemWrite;       // store wins when both are requested
        req_d.f3   = funct3;
        if (is_byte) begin
            aligned     = 1'b1;
            req_d.be    = 4'b0001 << ALUResult[1:0];
            req_d.wdata = {4{WriteData[7:0]}};
        end else if (is_half) begin
            aligned     = ~ALUResult[0];
            req_d.be    = ALUResult[1] ? 4'b1100 : 4'b0011;
            req_d.wdata = {2{WriteData[15:0]}};
        end else begin
            // 010 plus the unused 011/110/111 encodings all behave as words
            aligned     = (ALUResult[1:0] == 2'b00);
            req_d.be    = 4'b1111;
            req_d.wdata = WriteData;
        end
    end

    // Next-state and handshake outputs; reset forces Stall/MisalignErr low
    always_comb begin
        state_nxt   = state;
        Stall       = 1'b0;
        MisalignErr = 1'b0;
        accept      = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (aligned) begin
                        accept    = 1'b1;
                        Stall     = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        MisalignErr = 1'b1;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (mem.mem_ack) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            Stall       = 1'b0;
            MisalignErr = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture the request once; it stays frozen on the bus for the whole BUSY phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         req_q <= '0;
        else if (accept) req_q <= req_d;
    end

    assign mem.mem_req   = (state == BUSY);
    assign mem.mem_we    = req_q.we;
    assign mem.mem_be    = req_q.be;
    assign mem.mem_wdata = req_q.wdata;
    assign mem.mem_addr  = {req_q.addr[31:2], 2'b00};

    // Select the addressed byte/half and extend per funct3[2] (1 = unsigned)
    always_comb begin
        byte_v = mem.mem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
        half_v = req_q.addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (req_q.f3[1:0])
            2'b00:   load_val = {{24{byte_v[7] & ~req_q.f3[2]}}, byte_v};
            2'b01:   load_val = {{16{half_v[15] & ~req_q.f3[2]}}, half_v};
            default: load_val = mem.mem_rdata;
        endcase
    end

    // Load result register; stores and misaligned requests leave it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          ReadData <= '0;
        else if (state == BUSY && mem.mem_ack && !req_q.we) ReadData <= load_val;
        else if (timeout && !req_q.we)                    ReadData <= 32'hDEADBEEF;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] busy_cnt;
    logic          bus_err_q;

    // Count BUSY cycles, restarting on every accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                busy_cnt <= '0;
        else if (accept)        busy_cnt <= '0;
        else if (state == BUSY) busy_cnt <= busy_cnt + 1'b1;
    end

    assign timeout_hit = (state == BUSY) && (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

    // BusErr is high exactly in the DONE cycle that follows an abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus_err_q <= 1'b0;
        else     bus_err_q <= timeout;
    end

    assign BusErr = bus_err_q;
`else
    wire unused_timeout_cfg = ^TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign BusErr      = 1'b0;
`endif
endmodule
